cmd_sequencer_controller: RTL and testbench
===========================================

CMD_SEQUENCER_CONTROLLER -- requirements
Module: cmd_sequencer_controller

Interface
REQ-001 The module SHALL have parameter NUM_OF_DRIVERS, default 16, the number of sequencer drivers addressed (legal range 1..16).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, the number of command FIFO entries (power of two, 2..16).
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit; one clock, and reset is asynchronous and active-low.
REQ-005 The module SHALL have port cmd_data, input, 32 bits, the command word.
REQ-006 The module SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit), the command push handshake.
REQ-007 The module SHALL have ports control_trigger (input, 1) and update_cycle_complete (input, 1), the run-control events.
REQ-008 The module SHALL have ports mem_write_n, mem_dot_write_n and mem_sel_write_n, outputs, NUM_OF_DRIVERS bits each, the per-driver active-low write strobes.
REQ-009 The module SHALL have port write_config_n, output, 1 bit, the active-low config write strobe.
REQ-010 The module SHALL have ports mask_select[2:0], mem_address[6:0], config_address[5:0], mem_sel_col_address[6:0] and data_out[15:0], all outputs.
REQ-011 The module SHALL have ports timer_enable (output, 1), run_state[3:0] (output) and overflow (output, 1, sticky).
REQ-012 The module SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-013 Push: cmd_ready SHALL equal ~full; a word SHALL be written when cmd_valid & cmd_ready at an edge.
REQ-014 cmd_valid while full SHALL drop the word and set overflow, which is cleared only by reset.
REQ-015 Pop: when the FIFO is non-empty, one word per cycle SHALL be popped into the command register cmd; FIFO order SHALL be strict (oldest first).
REQ-016 Simultaneous push and pop SHALL leave fifo_level unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Decode fields of cmd: section=cmd[31:30], sel=cmd[29:26], mask=cmd[25:23], mc_sel=cmd[22], mem_address=cmd[22:16], config_address=cmd[21:16], mem_sel_col_address=cmd[14:8], data_out=cmd[15:0].
REQ-018 Strobes SHALL be registered and low for exactly one cycle, in the cycle after cmd is loaded, so that a push at edge T gives a strobe low between edges T+2 and T+3.
REQ-019 Section 00 SHALL pulse mem_write_n[sel]; section 01 SHALL pulse mem_dot_write_n[sel]; each updates mask_select<=mask when loaded.
REQ-020 Section 10 SHALL pulse write_config_n if mc_sel=0 and SHALL pulse mem_sel_write_n[sel] if mc_sel=1; mask_select SHALL go to 0.
REQ-021 If sel >= NUM_OF_DRIVERS, no per-driver strobe SHALL fire; the command is otherwise consumed normally.
REQ-022 Back-to-back commands SHALL produce strobes on consecutive cycles with no gaps.
REQ-023 Section 11 (run) SHALL load ctl=cmd[29:26] and rep=cmd[15:0] (rep of 0 treated as 1); run mode SHALL persist until a non-run command is loaded.
REQ-024 Run states SHALL be encoded as IDLE=1, ACTIVE=2, TRIG_WAIT=3, NO_WAIT=4, CONT=5, ONESHOT=6, HOLD=7; an illegal encoding SHALL go to IDLE.
REQ-025 Run state transitions SHALL be:
  - IDLE -> ACTIVE if ctl[3].
  - ACTIVE -> TRIG_WAIT if ctl[2], else NO_WAIT.
  - TRIG_WAIT -> (ctl[1]?CONT:ONESHOT) on control_trigger.
  - NO_WAIT -> (ctl[1]?CONT:ONESHOT).
  - CONT stays in CONT.
  - ONESHOT: on update_cycle_complete, decrement remaining count; -> HOLD when it reaches 0.
  - HOLD -> ONESHOT (count reloaded from rep) on ctl[0] & control_trigger.
REQ-026 Leaving run mode or loading a run command with ctl[3]=0 SHALL force IDLE on the next edge (abort), including from CONT or ONESHOT.
REQ-027 A new run command while running SHALL restart the state machine from IDLE with the new ctl/rep.
REQ-028 timer_enable SHALL be registered and equal 1 in the cycle after run_state is CONT or ONESHOT, else 0.
REQ-029 The remaining count SHALL be 16 bits, loaded on entry to ONESHOT, with no underflow.

Reset
REQ-030 While reset_n=0, the module SHALL hold: FIFO empty, fifo_level=0, cmd_ready=0, cmd=0, all *_write_n=all ones, mask_select=0, run_state=IDLE, timer_enable=0, overflow=0, count=0.
REQ-031 cmd_ready SHALL rise in the first cycle after reset_n deasserts; reset mid-burst SHALL discard queued commands and suppress pending strobes.

Verification
REQ-032 Push 0x0840_1234 (section 00, sel 2) -> mem_write_n=0xFFFB for one cycle two edges after accept; mem_address=0x40, data_out=0x1234, mask_select=0.
REQ-033 Push 5 words back-to-back with FIFO_DEPTH=4 and no stall -> all accepted (pop concurrent), 5 strobes on consecutive cycles, overflow=0.
REQ-034 Freeze pops via a run command at the FIFO head then fill -> cmd_ready=0 at level 4; an extra cmd_valid sets overflow=1 and that word is never strobed.
REQ-035 Run ctl=1100, rep=3, pulse control_trigger -> TRIG_WAIT->ONESHOT; three update_cycle_complete pulses -> HOLD; timer_enable drops one cycle later.
REQ-036 Run ctl=1010 -> NO_WAIT->CONT, timer_enable=1; then push a section-00 command -> IDLE next edge, timer_enable=0.
REQ-037 Assert reset_n low mid-ONESHOT with 3 words queued -> run_state=IDLE, fifo_level=0 and strobes all ones immediately, with no clock needed.

Source files
------------

// File: rtl/cmd_sequencer_controller.sv
// Command sequencer: queues 32-bit command words, decodes them into one-cycle
// active-low write strobes, and runs a small run-control state machine.
//
// state     | meaning
// IDLE      | no run in progress, or waiting for a run command with ctl[3]=1
// ACTIVE    | run accepted, choosing between trigger-wait and immediate start
// TRIG_WAIT | waiting for control_trigger
// NO_WAIT   | start without a trigger
// CONT      | continuous run, timer enabled until a new command is loaded
// ONESHOT   | counting update_cycle_complete pulses down from rep
// HOLD      | one-shot finished; ctl[0] & control_trigger re-arms it
module cmd_sequencer_controller #(
  parameter int NUM_OF_DRIVERS = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [31:0]                   cmd_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          control_trigger,
  input  logic                          update_cycle_complete,
  output logic [NUM_OF_DRIVERS-1:0]     mem_write_n,
  output logic [NUM_OF_DRIVERS-1:0]     mem_dot_write_n,
  output logic [NUM_OF_DRIVERS-1:0]     mem_sel_write_n,
  output logic                          write_config_n,
  output logic [2:0]                    mask_select,
  output logic [6:0]                    mem_address,
  output logic [5:0]                    config_address,
  output logic [6:0]                    mem_sel_col_address,
  output logic [15:0]                   data_out,
  output logic                          timer_enable,
  output logic [3:0]                    run_state,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd1,
    S_ACTIVE    = 4'd2,
    S_TRIG_WAIT = 4'd3,
    S_NO_WAIT   = 4'd4,
    S_CONT      = 4'd5,
    S_ONESHOT   = 4'd6,
    S_HOLD      = 4'd7
  } run_state_t;

  logic [31:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      rdy_q;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      stall;
  logic [31:0]               head;
  logic [31:0]               cmd;
  logic                      cmd_vld;
  logic [NUM_OF_DRIVERS-1:0] sel_hot;

  run_state_t                state;
  logic                      run_mode;
  logic [3:0]                ctl;
  logic [15:0]               rep;
  logic [15:0]               count;

  assign full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign empty     = (fifo_level == '0);
  assign cmd_ready = rdy_q & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr];
  assign run_state = state;

  // A run that has not yet reached CONT or HOLD owns the queue: later commands
  // stay queued so they cannot abort it before it has started or finished.
  assign stall = run_mode & ctl[3] & (state != S_CONT) & (state != S_HOLD);
  assign pop   = ~empty & ~stall;

  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NUM_OF_DRIVERS; i++)
      sel_hot[i] = (32'(cmd[29:26]) == i);
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rdy_q      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (cmd_valid && rdy_q && full)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd                 <= '0;
      cmd_vld             <= 1'b0;
      mem_write_n         <= '1;
      mem_dot_write_n     <= '1;
      mem_sel_write_n     <= '1;
      write_config_n      <= 1'b1;
      mask_select         <= '0;
      mem_address         <= '0;
      config_address      <= '0;
      mem_sel_col_address <= '0;
      data_out            <= '0;
    end else begin
      cmd_vld <= pop;
      if (pop)
        cmd <= head;
      mem_write_n     <= '1;
      mem_dot_write_n <= '1;
      mem_sel_write_n <= '1;
      write_config_n  <= 1'b1;
      // Address and data are registered with the strobe so they stay aligned
      // even when the next command is already sitting in cmd.
      if (cmd_vld && (cmd[31:30] != 2'b11)) begin
        mem_address         <= cmd[22:16];
        config_address      <= cmd[21:16];
        mem_sel_col_address <= cmd[14:8];
        data_out            <= cmd[15:0];
      end
      if (cmd_vld) begin
        case (cmd[31:30])
          2'b00: begin
            mem_write_n <= ~sel_hot;
            mask_select <= cmd[25:23];
          end
          2'b01: begin
            mem_dot_write_n <= ~sel_hot;
            mask_select     <= cmd[25:23];
          end
          2'b10: begin
            if (cmd[22])
              mem_sel_write_n <= ~sel_hot;
            else
              write_config_n <= 1'b0;
            mask_select <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      run_mode     <= 1'b0;
      ctl          <= '0;
      rep          <= '0;
      count        <= '0;
      timer_enable <= 1'b0;
    end else begin
      timer_enable <= (state == S_CONT) || (state == S_ONESHOT);
      if (pop) begin
        // Any newly loaded command restarts or aborts the run.
        state    <= S_IDLE;
        run_mode <= (head[31:30] == 2'b11);
        if (head[31:30] == 2'b11) begin
          ctl <= head[29:26];
          rep <= (head[15:0] == 16'd0) ? 16'd1 : head[15:0];
        end
      end else begin
        case (state)
          S_IDLE:
            if (run_mode && ctl[3])
              state <= S_ACTIVE;
          S_ACTIVE:
            state <= ctl[2] ? S_TRIG_WAIT : S_NO_WAIT;
          S_TRIG_WAIT:
            if (control_trigger) begin
              state <= ctl[1] ? S_CONT : S_ONESHOT;
              count <= rep;
            end
          S_NO_WAIT: begin
            state <= ctl[1] ? S_CONT : S_ONESHOT;
            count <= rep;
          end
          S_CONT:
            state <= S_CONT;
          S_ONESHOT:
            if (update_cycle_complete) begin
              if (count <= 16'd1) begin
                count <= '0;
                state <= S_HOLD;
              end else begin
                count <= count - 16'd1;
              end
            end
          S_HOLD:
            if (ctl[0] && control_trigger) begin
              state <= S_ONESHOT;
              count <= rep;
            end
          default:
            state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer_controller.sv
// Self-checking bench for cmd_sequencer_controller: a strobe scoreboard fed at
// push time and drained by a negedge monitor, plus per-scenario run checks.
module tb_cmd_sequencer_controller;

  localparam int NUM = 16;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        control_trigger;
  logic        update_cycle_complete;
  logic [NUM-1:0] mem_write_n;
  logic [NUM-1:0] mem_dot_write_n;
  logic [NUM-1:0] mem_sel_write_n;
  logic        write_config_n;
  logic [2:0]  mask_select;
  logic [6:0]  mem_address;
  logic [5:0]  config_address;
  logic [6:0]  mem_sel_col_address;
  logic [15:0] data_out;
  logic        timer_enable;
  logic [3:0]  run_state;
  logic        overflow;
  logic [2:0]  fifo_level;

  cmd_sequencer_controller #(.NUM_OF_DRIVERS(NUM), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .control_trigger(control_trigger),
    .update_cycle_complete(update_cycle_complete), .mem_write_n(mem_write_n),
    .mem_dot_write_n(mem_dot_write_n), .mem_sel_write_n(mem_sel_write_n),
    .write_config_n(write_config_n), .mask_select(mask_select),
    .mem_address(mem_address), .config_address(config_address),
    .mem_sel_col_address(mem_sel_col_address), .data_out(data_out),
    .timer_enable(timer_enable), .run_state(run_state), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [87:0] sb[$];
  int stb_count = 0;
  int unsigned stb_last = 0;
  int unsigned acc_cyc = 0;

  function automatic logic [31:0] mkw(input logic [1:0] s, input logic [3:0] sel,
                                      input logic [2:0] m, input logic [22:0] low);
    return {s, sel, m, low};
  endfunction

  // Expected strobe record for one word; has=0 when the word fires no strobe.
  function automatic logic [87:0] exp_of(input logic [31:0] w, output bit has);
    logic [15:0] mw, md, ms;
    logic cfg;
    logic [2:0] m;
    int sel;
    mw = 16'hFFFF; md = 16'hFFFF; ms = 16'hFFFF; cfg = 1'b1; m = 3'd0; has = 0;
    sel = int'(w[29:26]);
    case (w[31:30])
      2'b00: begin m = w[25:23]; if (sel < NUM) begin mw[sel] = 1'b0; has = 1; end end
      2'b01: begin m = w[25:23]; if (sel < NUM) begin md[sel] = 1'b0; has = 1; end end
      2'b10: begin
        if (!w[22]) begin cfg = 1'b0; has = 1; end
        else if (sel < NUM) begin ms[sel] = 1'b0; has = 1; end
      end
      default: has = 0;
    endcase
    return {mw, md, ms, cfg, m, w[22:16], w[21:16], w[14:8], w[15:0]};
  endfunction

  task automatic monitor_strobes();
    logic [87:0] obs, exp;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 &&
          ((&mem_write_n) & (&mem_dot_write_n) & (&mem_sel_write_n) & write_config_n) !== 1'b1) begin
        obs = {mem_write_n, mem_dot_write_n, mem_sel_write_n, write_config_n, mask_select,
               mem_address, config_address, mem_sel_col_address, data_out};
        stb_count++;
        stb_last = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL strobe_spurious: got %h, expected no strobe", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL strobe: got %h, expected %h", obs, exp);
          end
        end
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit exp_acc, input bit modeled);
    bit has;
    logic [87:0] e;
    @(negedge clock);
    cmd_data = w;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== exp_acc) begin
      errors++;
      $display("FAIL cmd_ready(push %h): got %b, expected %b", w, cmd_ready, exp_acc);
    end
    e = exp_of(w, has);
    if (exp_acc && modeled && has) sb.push_back(e);
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse(input bit is_ucc);
    @(posedge clock); #1;
    if (is_ucc) update_cycle_complete = 1'b1; else control_trigger = 1'b1;
    @(posedge clock); #1;
    update_cycle_complete = 1'b0;
    control_trigger = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d strobes still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({cmd_ready, fifo_level, run_state, timer_enable, overflow} !== {1'b0, 3'd0, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b lvl=%0d st=%0d te=%b ovf=%b, expected 0 0 1 0 0",
               cmd_ready, fifo_level, run_state, timer_enable, overflow);
    end
    checks++;
    if ({mem_write_n, mem_dot_write_n, mem_sel_write_n, write_config_n, mask_select} !== {49'h1_FFFF_FFFF_FFFF, 3'd0}) begin
      errors++;
      $display("FAIL reset_strobes: got %h %h %h %b mask %0d, expected all ones, mask 0",
               mem_write_n, mem_dot_write_n, mem_sel_write_n, write_config_n, mask_select);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b, expected 0", cmd_ready);
    end
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, expected 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    push_word(32'h0840_1234, 1'b1, 1'b1);
    drain("single");
    checks++;
    if (stb_last != acc_cyc + 2) begin
      errors++;
      $display("FAIL strobe_latency: strobe at cycle %0d, expected %0d", stb_last, acc_cyc + 2);
    end
  endtask

  task automatic test_sections();
    push_word(mkw(2'd1, 4'd5, 3'd3, 23'h5A7C3E), 1'b1, 1'b1);
    push_word(mkw(2'd2, 4'd9, 3'd6, 23'h151234), 1'b1, 1'b1);
    push_word(mkw(2'd2, 4'd7, 3'd1, 23'h4A5678), 1'b1, 1'b1);
    push_word(mkw(2'd0, 4'd15, 3'd7, 23'h7FFFFF), 1'b1, 1'b1);
    push_word(mkw(2'd1, 4'd0, 3'd2, 23'h000001), 1'b1, 1'b1);
    drain("sections");
  endtask

  task automatic test_back_to_back();
    int base;
    int unsigned first_acc;
    base = stb_count;
    for (int i = 0; i < 5; i++) begin
      push_word(mkw(2'd0, 4'(i + 1), 3'(i), {7'(i * 9), 16'hA500 + 16'(i)}), 1'b1, 1'b1);
      if (i == 0) first_acc = acc_cyc;
    end
    drain("b2b");
    checks++;
    if (stb_count - base != 5 || stb_last != first_acc + 6) begin
      errors++;
      $display("FAIL back_to_back: %0d strobes last at %0d, expected 5 last at %0d",
               stb_count - base, stb_last, first_acc + 6);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_overflow_oneshot();
    push_word(32'hF000_0003, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      push_word(mkw(2'd1, 4'(i + 2), 3'd5, 23'h300000 + 23'(i)), 1'b1, 1'b1);
    @(negedge clock);
    checks++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: level %0d ready %b, expected 4 0", fifo_level, cmd_ready);
    end
    push_word(mkw(2'd0, 4'd1, 3'd1, 23'h0BAD00), 1'b0, 1'b1);
    @(negedge clock);
    checks++;
    if (overflow !== 1'b1 || run_state !== 4'd3) begin
      errors++;
      $display("FAIL overflow: ovf %b state %0d, expected 1 3", overflow, run_state);
    end
    pulse(1'b0);
    @(negedge clock);
    checks++;
    if (run_state !== 4'd6 || timer_enable !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_entry: state %0d te %b, expected 6 0", run_state, timer_enable);
    end
    @(negedge clock);
    checks++;
    if (timer_enable !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_timer: got %b, expected 1", timer_enable);
    end
    for (int i = 0; i < 2; i++) pulse(1'b1);
    @(negedge clock);
    checks++;
    if (run_state !== 4'd6) begin
      errors++;
      $display("FAIL oneshot_count: state %0d after 2 pulses, expected 6", run_state);
    end
    pulse(1'b1);
    @(negedge clock);
    checks++;
    if (run_state !== 4'd7 || timer_enable !== 1'b1) begin
      errors++;
      $display("FAIL hold_entry: state %0d te %b, expected 7 1", run_state, timer_enable);
    end
    @(negedge clock);
    checks++;
    if (timer_enable !== 1'b0) begin
      errors++;
      $display("FAIL hold_timer: got %b, expected 0", timer_enable);
    end
    drain("oneshot");
  endtask

  task automatic test_cont_abort();
    int n;
    push_word(32'hE800_0000, 1'b1, 1'b1);
    n = 0;
    while (run_state !== 4'd5 && n < 10) begin @(negedge clock); n++; end
    @(negedge clock);
    checks++;
    if (run_state !== 4'd5 || timer_enable !== 1'b1) begin
      errors++;
      $display("FAIL cont: state %0d te %b, expected 5 1", run_state, timer_enable);
    end
    push_word(mkw(2'd0, 4'd3, 3'd4, 23'h2200AA), 1'b1, 1'b1);
    n = 0;
    while (run_state !== 4'd1 && n < 4) begin @(negedge clock); n++; end
    checks++;
    if (run_state !== 4'd1) begin
      errors++;
      $display("FAIL abort_state: got %0d, expected 1", run_state);
    end
    @(negedge clock);
    checks++;
    if (timer_enable !== 1'b0) begin
      errors++;
      $display("FAIL abort_timer: got %b, expected 0", timer_enable);
    end
    drain("cont");
  endtask

  task automatic test_reset_mid();
    int n;
    int base;
    push_word(32'hF000_0005, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_word(mkw(2'd0, 4'(i), 3'd2, 23'h11 * 23'(i + 1)), 1'b1, 1'b0);
    n = 0;
    while (run_state !== 4'd3 && n < 10) begin @(negedge clock); n++; end
    pulse(1'b0);
    pulse(1'b1);
    @(negedge clock);
    checks++;
    if (run_state !== 4'd6 || fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL mid_oneshot: state %0d level %0d, expected 6 3", run_state, fifo_level);
    end
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({run_state, fifo_level, cmd_ready, timer_enable, overflow} !== {4'd1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: st %0d lvl %0d rdy %b te %b ovf %b, expected 1 0 0 0 0",
               run_state, fifo_level, cmd_ready, timer_enable, overflow);
    end
    checks++;
    if ({mem_write_n, mem_dot_write_n, mem_sel_write_n, write_config_n} !== 49'h1_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL async_reset_strobes: got %h %h %h %b, expected all ones",
               mem_write_n, mem_dot_write_n, mem_sel_write_n, write_config_n);
    end
    base = stb_count;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (stb_count != base || fifo_level !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset: %0d strobes level %0d pending %0d, expected 0 0 0",
               stb_count - base, fifo_level, sb.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_data = '0;
    cmd_valid = 1'b0;
    control_trigger = 1'b0;
    update_cycle_complete = 1'b0;
    fork
      monitor_strobes();
    join_none
    test_reset();
    test_single();
    test_sections();
    test_back_to_back();
    test_overflow_oneshot();
    test_cont_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
